sobel_edge_detector: RTL and testbench

SOBEL_EDGE_DETECTOR -- requirements
Module: sobel_edge_detector

---
 rtl/sobel_edge_detector_if.sv | 27 ++
 rtl/sobel_edge_detector.sv | 185 ++++++++++++++++++
 tb/tb_sobel_edge_detector.sv | 239 +++++++++++++++++++++++
 3 files changed

// File: rtl/sobel_edge_detector_if.sv
// Pixel-matrix input and edge-result output bundle for sobel_edge_detector.
interface sobel_edge_detector_if #(
  parameter int P_SUBPIXEL_DEPTH = 8
);
  logic [8*P_SUBPIXEL_DEPTH-1:0] I_PIXEL_MATRIX;
  logic [9:0]                    I_PIXEL_COLUMN;
  logic [8:0]                    I_PIXEL_ROW;
  logic                          I_PIXEL_MATRIX_READY;
  logic [P_SUBPIXEL_DEPTH-1:0]   I_THRESHOLD;
  logic [P_SUBPIXEL_DEPTH-1:0]   O_PIXEL;
  logic                          O_EDGE;
  logic [9:0]                    O_PIXEL_COLUMN;
  logic [8:0]                    O_PIXEL_ROW;
  logic                          O_PIXEL_VALID;
  logic                          O_FRAME_DONE;
  logic [18:0]                   O_EDGE_COUNT;

  modport master (
    output I_PIXEL_MATRIX, I_PIXEL_COLUMN, I_PIXEL_ROW, I_PIXEL_MATRIX_READY, I_THRESHOLD,
    input  O_PIXEL, O_EDGE, O_PIXEL_COLUMN, O_PIXEL_ROW, O_PIXEL_VALID, O_FRAME_DONE, O_EDGE_COUNT
  );

  modport slave (
    input  I_PIXEL_MATRIX, I_PIXEL_COLUMN, I_PIXEL_ROW, I_PIXEL_MATRIX_READY, I_THRESHOLD,
    output O_PIXEL, O_EDGE, O_PIXEL_COLUMN, O_PIXEL_ROW, O_PIXEL_VALID, O_FRAME_DONE, O_EDGE_COUNT
  );
endinterface

// File: rtl/sobel_edge_detector.sv
// Three-stage Sobel gradient magnitude with per-frame threshold and edge counting.
module sobel_edge_detector #(
  parameter int P_FRAME_COLUMNS  = 640,
  parameter int P_FRAME_ROWS     = 480,
  parameter int P_SUBPIXEL_DEPTH = 8
) (
  input logic I_CLK,
  input logic I_RESET,
  sobel_edge_detector_if.slave bus
);

  localparam int D = P_SUBPIXEL_DEPTH;
  localparam int W = D + 3;  // signed gradient width
  localparam int A = D + 2;  // gradient magnitude width
  localparam logic [9:0]   LAST_COL = 10'(P_FRAME_COLUMNS - 1);
  localparam logic [8:0]   LAST_ROW = 9'(P_FRAME_ROWS - 1);
  localparam logic [W-1:0] PIX_MAX  = W'((1 << D) - 1);

  // ---------------- input decode ----------------
  logic [D-1:0] px [8];
  logic [W-1:0] gx_pos, gx_neg, gy_pos, gy_neg;
  logic         in_valid, in_first, in_border;
  logic [D-1:0] thr_q, thr_in;

  assign in_valid = bus.I_PIXEL_MATRIX_READY;

  // px order: TL, T, TR, ML, MR, BL, B, BR
  always_comb begin
    for (int unsigned i = 0; i < 8; i++) begin
      px[i] = bus.I_PIXEL_MATRIX[(7 - i)*D +: D];
    end
    gx_pos = W'(px[2]) + (W'(px[4]) << 1) + W'(px[7]);
    gx_neg = W'(px[0]) + (W'(px[3]) << 1) + W'(px[5]);
    gy_pos = W'(px[5]) + (W'(px[6]) << 1) + W'(px[7]);
    gy_neg = W'(px[0]) + (W'(px[1]) << 1) + W'(px[2]);
  end

  assign in_first  = (bus.I_PIXEL_COLUMN == '0) && (bus.I_PIXEL_ROW == '0);
  assign in_border = (bus.I_PIXEL_COLUMN == '0) || (bus.I_PIXEL_COLUMN == LAST_COL) ||
                     (bus.I_PIXEL_ROW == '0)    || (bus.I_PIXEL_ROW == LAST_ROW);
  // The threshold travels with each sample so tail pixels of the previous
  // frame still in flight are judged against their own frame's threshold.
  assign thr_in = in_first ? bus.I_THRESHOLD : thr_q;

  // ---------------- stage 1: signed gradients ----------------
  logic         s1_valid, s1_border;
  logic [W-1:0] s1_gx, s1_gy;
  logic [9:0]   s1_col;
  logic [8:0]   s1_row;
  logic [D-1:0] s1_thr;

  always_ff @(posedge I_CLK) begin
    if (I_RESET) begin
      thr_q     <= '0;
      s1_valid  <= 1'b0;
      s1_border <= 1'b0;
      s1_gx     <= '0;
      s1_gy     <= '0;
      s1_col    <= '0;
      s1_row    <= '0;
      s1_thr    <= '0;
    end else begin
      s1_valid <= in_valid;
      if (in_valid) begin
        if (in_first) thr_q <= bus.I_THRESHOLD;
        s1_gx     <= gx_pos - gx_neg;
        s1_gy     <= gy_pos - gy_neg;
        s1_col    <= bus.I_PIXEL_COLUMN;
        s1_row    <= bus.I_PIXEL_ROW;
        s1_border <= in_border;
        s1_thr    <= thr_in;
      end
    end
  end

  // ---------------- stage 2: magnitudes ----------------
  logic [A-1:0] abs_x, abs_y;
  logic         s2_valid, s2_border;
  logic [A-1:0] s2_ax, s2_ay;
  logic [9:0]   s2_col;
  logic [8:0]   s2_row;
  logic [D-1:0] s2_thr;

  // |g| fits in A bits, so negating only the low A bits is exact
  assign abs_x = s1_gx[W-1] ? (~s1_gx[A-1:0] + A'(1)) : s1_gx[A-1:0];
  assign abs_y = s1_gy[W-1] ? (~s1_gy[A-1:0] + A'(1)) : s1_gy[A-1:0];

  always_ff @(posedge I_CLK) begin
    if (I_RESET) begin
      s2_valid  <= 1'b0;
      s2_border <= 1'b0;
      s2_ax     <= '0;
      s2_ay     <= '0;
      s2_col    <= '0;
      s2_row    <= '0;
      s2_thr    <= '0;
    end else begin
      s2_valid <= s1_valid;
      if (s1_valid) begin
        s2_ax     <= abs_x;
        s2_ay     <= abs_y;
        s2_col    <= s1_col;
        s2_row    <= s1_row;
        s2_border <= s1_border;
        s2_thr    <= s1_thr;
      end
    end
  end

  // ---------------- stage 3: sum, saturate, threshold ----------------
  logic [W-1:0] mag_sum;
  logic [D-1:0] pix_next;
  logic         edge_next;

  always_comb begin
    mag_sum   = {1'b0, s2_ax} + {1'b0, s2_ay};
    pix_next  = '0;
    edge_next = 1'b0;
    if (!s2_border) begin
      pix_next  = (mag_sum > PIX_MAX) ? '1 : mag_sum[D-1:0];
      edge_next = (pix_next >= s2_thr);
    end
  end

  logic         out_valid, out_edge;
  logic [D-1:0] out_pix;
  logic [9:0]   out_col;
  logic [8:0]   out_row;

  always_ff @(posedge I_CLK) begin
    if (I_RESET) begin
      out_valid <= 1'b0;
      out_edge  <= 1'b0;
      out_pix   <= '0;
      out_col   <= '0;
      out_row   <= '0;
    end else begin
      out_valid <= s2_valid;
      out_edge  <= s2_valid && edge_next;
      if (s2_valid) begin
        out_pix <= pix_next;
        out_col <= s2_col;
        out_row <= s2_row;
      end
    end
  end

  // ---------------- frame edge counter ----------------
  logic        out_first, out_last;
  logic [18:0] cnt_q, cnt_sum;
  logic        done_q;
  logic [18:0] edge_count_q;

  assign out_first = (out_col == '0) && (out_row == '0);
  assign out_last  = (out_col == LAST_COL) && (out_row == LAST_ROW);
  assign cnt_sum   = (out_first ? '0 : cnt_q) + 19'(out_edge);

  always_ff @(posedge I_CLK) begin
    if (I_RESET) begin
      cnt_q        <= '0;
      done_q       <= 1'b0;
      edge_count_q <= '0;
    end else begin
      done_q <= 1'b0;
      if (out_valid) begin
        if (out_last) begin
          done_q       <= 1'b1;
          edge_count_q <= cnt_sum;
          cnt_q        <= '0;
        end else begin
          cnt_q <= cnt_sum;
        end
      end
    end
  end

  assign bus.O_PIXEL        = out_pix;
  assign bus.O_EDGE         = out_edge;
  assign bus.O_PIXEL_COLUMN = out_col;
  assign bus.O_PIXEL_ROW    = out_row;
  assign bus.O_PIXEL_VALID  = out_valid;
  assign bus.O_FRAME_DONE   = done_q;
  assign bus.O_EDGE_COUNT   = edge_count_q;

endmodule

// File: tb/tb_sobel_edge_detector.sv
// Scoreboard bench for sobel_edge_detector on a reduced 40x30 frame.
module tb_sobel_edge_detector;

  localparam int COLS = 40;
  localparam int ROWS = 30;
  localparam logic [63:0] EDGE_MAT = 64'h0000_FF00_FF00_00FF;
  localparam logic [63:0] TEN_MAT  = 64'h0000_0A00_0A00_000A;
  localparam logic [63:0] FLAT100  = 64'h6464_6464_6464_6464;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  sobel_edge_detector_if #(.P_SUBPIXEL_DEPTH(8)) bus ();

  sobel_edge_detector #(
    .P_FRAME_COLUMNS (COLS),
    .P_FRAME_ROWS    (ROWS),
    .P_SUBPIXEL_DEPTH(8)
  ) dut (
    .I_CLK  (clk),
    .I_RESET(rst),
    .bus    (bus)
  );

  typedef struct {
    int     pix;
    int     edg;
    int     col;
    int     row;
    longint due;
  } exp_t;

  exp_t   sb[$];
  int     checks    = 0;
  int     failures  = 0;
  longint cyc       = 0;
  int     mthr      = 0;
  int     mcount    = 0;
  int     exp_cnt   = 0;
  longint done_due  = -1;
  int     done_seen = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input longint got, input longint exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0d exp=%0d (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic bit is_border(input int col, input int row);
    return (col == 0) || (col == COLS - 1) || (row == 0) || (row == ROWS - 1);
  endfunction

  function automatic int model_pix(input logic [63:0] m, input int col, input int row);
    int tl, t, tr, ml, mr, bl, b, br, gx, gy, s;
    if (is_border(col, row)) return 0;
    tl = int'(m[63:56]); t  = int'(m[55:48]); tr = int'(m[47:40]); ml = int'(m[39:32]);
    mr = int'(m[31:24]); bl = int'(m[23:16]); b  = int'(m[15:8]);  br = int'(m[7:0]);
    gx = (tr + 2*mr + br) - (tl + 2*ml + bl);
    gy = (bl + 2*b + br) - (tl + 2*t + tr);
    s  = (gx < 0 ? -gx : gx) + (gy < 0 ? -gy : gy);
    return (s > 255) ? 255 : s;
  endfunction

  task automatic drive(input logic [63:0] m, input int col, input int row, input int thr,
                       input bit rdy, input bit push);
    exp_t e;
    @(posedge clk); #1;
    bus.I_PIXEL_MATRIX       = m;
    bus.I_PIXEL_COLUMN       = 10'(col);
    bus.I_PIXEL_ROW          = 9'(row);
    bus.I_THRESHOLD          = 8'(thr);
    bus.I_PIXEL_MATRIX_READY = rdy;
    if (rdy) begin
      if (col == 0 && row == 0) mthr = thr;
      if (push) begin
        e.pix = model_pix(m, col, row);
        e.edg = (!is_border(col, row) && e.pix >= mthr) ? 1 : 0;
        e.col = col;
        e.row = row;
        e.due = cyc + 3;
        sb.push_back(e);
      end
    end
  endtask

  task automatic idle(input int n);
    repeat (n) drive({$urandom, $urandom}, int'($urandom_range(0, COLS - 1)),
                     int'($urandom_range(0, ROWS - 1)), int'($urandom_range(0, 255)), 1'b0, 1'b0);
  endtask

  task automatic wait_drain();
    for (int i = 0; i < 100 && sb.size() != 0; i++) @(negedge clk);
    check("sb_drain", longint'(sb.size()), 0);
  endtask

  task automatic send_frame(input int n_edges, input int thr);
    int idx = 0;
    logic [63:0] m;
    logic [7:0]  v;
    for (int r = 0; r < ROWS; r++) begin
      for (int c = 0; c < COLS; c++) begin
        if ($urandom_range(0, 3) == 0) idle(int'($urandom_range(1, 3)));
        if (is_border(c, r)) begin
          m = {$urandom, $urandom};
        end else begin
          if (idx < n_edges) m = EDGE_MAT;
          else begin
            v = 8'($urandom);
            m = {8{v}};
          end
          idx++;
        end
        // only the frame's first sample carries the real threshold
        drive(m, c, r, (c == 0 && r == 0) ? thr : int'($urandom_range(0, 255)), 1'b1, 1'b1);
      end
    end
  endtask

  // Output monitor: scoreboard comparison, latency, frame-done and count model
  always @(negedge clk) begin
    exp_t e;
    bit   exp_done;
    if (rst) begin
      mcount   = 0;
      done_due = -1;
    end else begin
      exp_done = (cyc == done_due);
      if (bus.O_FRAME_DONE) done_seen++;
      if (bus.O_FRAME_DONE || exp_done) begin
        check("frame_done", longint'(bus.O_FRAME_DONE), longint'(exp_done));
        if (exp_done) check("edge_count", longint'(bus.O_EDGE_COUNT), exp_cnt);
      end
      if (bus.O_PIXEL_VALID) begin
        if (sb.size() == 0) begin
          check("spurious_valid", longint'(bus.O_PIXEL_VALID), 0);
        end else begin
          e = sb.pop_front();
          check("latency", cyc, e.due);
          check("pixel", longint'(bus.O_PIXEL), e.pix);
          check("edge", longint'(bus.O_EDGE), e.edg);
          check("column", longint'(bus.O_PIXEL_COLUMN), e.col);
          check("row", longint'(bus.O_PIXEL_ROW), e.row);
          if (e.col == 0 && e.row == 0) mcount = e.edg;
          else mcount += e.edg;
          if (e.col == COLS - 1 && e.row == ROWS - 1) begin
            exp_cnt  = mcount;
            done_due = cyc + 1;
            mcount   = 0;
          end
        end
      end else begin
        if (bus.O_EDGE) check("edge_when_idle", longint'(bus.O_EDGE), 0);
        if (sb.size() > 0 && cyc > sb[0].due) begin
          e = sb.pop_front();
          check("missing_output", cyc, e.due);
        end
      end
    end
  end

  initial begin
    bus.I_PIXEL_MATRIX       = '0;
    bus.I_PIXEL_COLUMN       = '0;
    bus.I_PIXEL_ROW          = '0;
    bus.I_THRESHOLD          = '0;
    bus.I_PIXEL_MATRIX_READY = 1'b0;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_valid", longint'(bus.O_PIXEL_VALID), 0);
    check("rst_edge", longint'(bus.O_EDGE), 0);
    check("rst_done", longint'(bus.O_FRAME_DONE), 0);
    check("rst_pixel", longint'(bus.O_PIXEL), 0);
    check("rst_column", longint'(bus.O_PIXEL_COLUMN), 0);
    check("rst_row", longint'(bus.O_PIXEL_ROW), 0);
    check("rst_count", longint'(bus.O_EDGE_COUNT), 0);
    @(posedge clk); #1;
    rst  = 1'b0;
    mthr = 0;

    // directed patterns, back to back
    drive(FLAT100, 0, 0, 128, 1'b1, 1'b1);
    drive(FLAT100, 5, 5, 77, 1'b1, 1'b1);
    drive(EDGE_MAT, 5, 6, 3, 1'b1, 1'b1);
    drive(EDGE_MAT, 0, 7, 3, 1'b1, 1'b1);
    drive(EDGE_MAT, 5, ROWS - 1, 3, 1'b1, 1'b1);
    drive(EDGE_MAT, COLS - 1, 8, 3, 1'b1, 1'b1);
    drive(TEN_MAT, 6, 5, 0, 1'b1, 1'b1);
    drive(FLAT100, 0, 0, 40, 1'b1, 1'b1);
    drive(TEN_MAT, 6, 5, 40, 1'b1, 1'b1);
    drive(TEN_MAT, 6, 6, 200, 1'b1, 1'b1);
    idle(2);
    drive(FLAT100, 0, 0, 41, 1'b1, 1'b1);
    drive(TEN_MAT, 6, 5, 0, 1'b1, 1'b1);
    for (int i = 0; i < 8; i++)
      drive({$urandom, $urandom}, int'($urandom_range(1, COLS - 2)),
            int'($urandom_range(1, ROWS - 2)), 0, 1'b1, 1'b1);
    idle(1);
    wait_drain();

    // full frames with gaps
    send_frame(1000, 128);
    idle(1);
    wait_drain();
    idle(3);
    @(negedge clk);
    check("count_hold", longint'(bus.O_EDGE_COUNT), 1000);
    send_frame(7, 200);
    idle(1);
    wait_drain();
    idle(3);

    // one-cycle reset with two samples in flight
    drive(EDGE_MAT, 5, 5, 0, 1'b1, 1'b0);
    drive(EDGE_MAT, 6, 5, 0, 1'b1, 1'b0);
    @(posedge clk); #1;
    rst = 1'b1;
    bus.I_PIXEL_MATRIX_READY = 1'b0;
    mthr = 0;
    @(posedge clk); #1;
    rst = 1'b0;
    idle(5);
    @(negedge clk);
    check("count_after_reset", longint'(bus.O_EDGE_COUNT), 0);
    drive(EDGE_MAT, 7, 7, 0, 1'b1, 1'b1);
    idle(1);
    wait_drain();
    idle(3);
    check("frames_done", done_seen, 2);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
